// File: rtl/branch_predictor_gshare_pkg.sv
// Shared definitions for the gshare branch predictor: mode encodings, FSM states and
// the pattern-table counter initial value.
package branch_predictor_gshare_pkg;

    localparam logic [1:0] MODE_STATIC  = 2'd0;
    localparam logic [1:0] MODE_BIMODAL = 2'd1;
    localparam logic [1:0] MODE_GSHARE  = 2'd2;
    localparam logic [1:0] MODE_GLOBAL  = 2'd3;

    typedef enum logic {
        StInit,
        StRun
    } state_e;

    // Weakly not-taken: all ones below the MSB.
    function automatic int unsigned ctr_init(input int unsigned ctr_bits);
        return (32'd1 << (ctr_bits - 32'd1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_gshare_sat_counter_update.sv
// Combinational saturating increment/decrement of one pattern-table counter.
module sat_counter_update #(
    parameter int unsigned CTR_BITS = 2
) (
    input  logic [CTR_BITS-1:0] i_ctr,
    input  logic                i_taken,
    output logic [CTR_BITS-1:0] o_ctr
);

    localparam logic [CTR_BITS-1:0] CtrMax = '1;
    localparam logic [CTR_BITS-1:0] CtrOne = CTR_BITS'(1);

    always_comb begin
        o_ctr = i_ctr;
        if (i_taken) begin
            if (i_ctr != CtrMax) o_ctr = i_ctr + CtrOne;
        end else begin
            if (i_ctr != '0) o_ctr = i_ctr - CtrOne;
        end
    end

endmodule

// File: rtl/branch_predictor_gshare.sv
// Run-time selectable bimodal/gshare/global predictor with speculative global history,
// EX-side repair on mispredict, and branch/mispredict performance counters.
module branch_predictor_gshare
    import branch_predictor_gshare_pkg::*;
#(
    parameter int unsigned HIST_BITS = 4,
    parameter int unsigned CTR_BITS  = 2,
    parameter int unsigned PC_BITS   = 32,
    parameter int unsigned CNT_BITS  = 16
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [1:0]           Mode,
    input  logic                 BranchInstructExists_ID,
    input  logic [PC_BITS-1:0]   PC_ID,
    output logic                 Prediction,
    output logic [HIST_BITS-1:0] PredIndex_ID,
    output logic [HIST_BITS-1:0] PredHistory_ID,
    input  logic                 BranchInstructExists_EX,
    input  logic                 BranchDecision_EX,
    input  logic                 Prediction_EX,
    input  logic [HIST_BITS-1:0] Index_EX,
    input  logic [HIST_BITS-1:0] History_EX,
    output logic                 Mispredict,
    output logic                 Ready,
    output logic [CNT_BITS-1:0]  BranchCount,
    output logic [CNT_BITS-1:0]  MispredictCount
);

    localparam int unsigned           Entries = 2 ** HIST_BITS;
    localparam logic [CTR_BITS-1:0]   CtrInit = CTR_BITS'(ctr_init(CTR_BITS));
    localparam logic [HIST_BITS-1:0]  PtrOne  = HIST_BITS'(1);
    localparam logic [CNT_BITS-1:0]   CntOne  = CNT_BITS'(1);

    logic [CTR_BITS-1:0]  r_pht [Entries];
    state_e               r_state;
    logic [HIST_BITS-1:0] r_ptr;
    logic [HIST_BITS-1:0] r_ghr;
    logic [CNT_BITS-1:0]  r_branch_cnt;
    logic [CNT_BITS-1:0]  r_mispredict_cnt;

    logic [HIST_BITS-1:0] w_pc_index;
    logic [HIST_BITS-1:0] w_index;
    logic [CTR_BITS-1:0]  w_pht_ex_next;
    logic                 w_ready;
    logic                 w_mispredict;
    logic                 w_unused;

    assign w_pc_index = PC_ID[HIST_BITS+1:2];

    always_comb begin
        w_index = w_pc_index;
        case (Mode)
            MODE_GSHARE: w_index = w_pc_index ^ r_ghr;
            MODE_GLOBAL: w_index = r_ghr;
            default:     w_index = w_pc_index;
        endcase
    end

    assign w_ready      = (r_state == StRun);
    assign w_mispredict = BranchInstructExists_EX & (Prediction_EX != BranchDecision_EX) & w_ready;

    assign Prediction      = w_ready & BranchInstructExists_ID & (Mode != MODE_STATIC) &
                             r_pht[w_index][CTR_BITS-1];
    assign PredIndex_ID    = BranchInstructExists_ID ? w_index : '0;
    assign PredHistory_ID  = r_ghr;
    assign Mispredict      = w_mispredict;
    assign Ready           = w_ready;
    assign BranchCount     = r_branch_cnt;
    assign MispredictCount = r_mispredict_cnt;

    sat_counter_update #(
        .CTR_BITS (CTR_BITS)
    ) u_sat_counter_update (
        .i_ctr   (r_pht[Index_EX]),
        .i_taken (BranchDecision_EX),
        .o_ctr   (w_pht_ex_next)
    );

    // No write in the reset cycle; INIT rewrites every entry afterwards.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (r_state == StInit) begin
                r_pht[r_ptr] <= CtrInit;
            end else if (BranchInstructExists_EX) begin
                r_pht[Index_EX] <= w_pht_ex_next;
            end
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state          <= StInit;
            r_ptr            <= '0;
            r_ghr            <= '0;
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else begin
            case (r_state)
                StInit: begin
                    r_ptr <= r_ptr + PtrOne;
                    if (r_ptr == '1) r_state <= StRun;
                end
                StRun: begin
                    // Repair beats the speculative shift: the ID branch is being flushed.
                    if (w_mispredict) begin
                        r_ghr <= {History_EX[HIST_BITS-2:0], BranchDecision_EX};
                    end else if (BranchInstructExists_ID) begin
                        r_ghr <= {r_ghr[HIST_BITS-2:0], Prediction};
                    end
                    if (BranchInstructExists_EX) r_branch_cnt <= r_branch_cnt + CntOne;
                    if (w_mispredict) r_mispredict_cnt <= r_mispredict_cnt + CntOne;
                end
                default: r_state <= StInit;
            endcase
        end
    end

    assign w_unused = ^{PC_ID[PC_BITS-1:HIST_BITS+2], PC_ID[1:0], History_EX[HIST_BITS-1]};

endmodule

// File: tb/tb_branch_predictor_gshare.sv
// Directed scoreboard bench for branch_predictor_gshare: stimulus queues expected outputs
// tagged by cycle, a negedge monitor pops and compares them.
module tb_branch_predictor_gshare;

    localparam int unsigned HB = 4;
    localparam int unsigned CB = 2;
    localparam int unsigned PB = 32;
    localparam int unsigned NB = 16;

    localparam int S_PRED = 0;
    localparam int S_IDX  = 1;
    localparam int S_HIST = 2;
    localparam int S_MISP = 3;
    localparam int S_RDY  = 4;
    localparam int S_BCNT = 5;
    localparam int S_MCNT = 6;

    logic          Clock;
    logic          Reset;
    logic [1:0]    Mode;
    logic          BranchInstructExists_ID;
    logic [PB-1:0] PC_ID;
    logic          Prediction;
    logic [HB-1:0] PredIndex_ID;
    logic [HB-1:0] PredHistory_ID;
    logic          BranchInstructExists_EX;
    logic          BranchDecision_EX;
    logic          Prediction_EX;
    logic [HB-1:0] Index_EX;
    logic [HB-1:0] History_EX;
    logic          Mispredict;
    logic          Ready;
    logic [NB-1:0] BranchCount;
    logic [NB-1:0] MispredictCount;

    branch_predictor_gshare #(
        .HIST_BITS (HB),
        .CTR_BITS  (CB),
        .PC_BITS   (PB),
        .CNT_BITS  (NB)
    ) dut (
        .Clock                   (Clock),
        .Reset                   (Reset),
        .Mode                    (Mode),
        .BranchInstructExists_ID (BranchInstructExists_ID),
        .PC_ID                   (PC_ID),
        .Prediction              (Prediction),
        .PredIndex_ID            (PredIndex_ID),
        .PredHistory_ID          (PredHistory_ID),
        .BranchInstructExists_EX (BranchInstructExists_EX),
        .BranchDecision_EX       (BranchDecision_EX),
        .Prediction_EX           (Prediction_EX),
        .Index_EX                (Index_EX),
        .History_EX              (History_EX),
        .Mispredict              (Mispredict),
        .Ready                   (Ready),
        .BranchCount             (BranchCount),
        .MispredictCount         (MispredictCount)
    );

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic logic [31:0] actual(input int sel);
        case (sel)
            S_PRED:  return {31'd0, Prediction};
            S_IDX:   return {28'd0, PredIndex_ID};
            S_HIST:  return {28'd0, PredHistory_ID};
            S_MISP:  return {31'd0, Mispredict};
            S_RDY:   return {31'd0, Ready};
            S_BCNT:  return {16'd0, BranchCount};
            default: return {16'd0, MispredictCount};
        endcase
    endfunction

    function automatic string sel_name(input int sel);
        case (sel)
            S_PRED:  return "Prediction";
            S_IDX:   return "PredIndex_ID";
            S_HIST:  return "PredHistory_ID";
            S_MISP:  return "Mispredict";
            S_RDY:   return "Ready";
            S_BCNT:  return "BranchCount";
            default: return "MispredictCount";
        endcase
    endfunction

    always @(negedge Clock) begin : monitor
        exp_t e;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            checks++;
            if (actual(e.sel) !== e.exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got 0x%0h, expected 0x%0h",
                         sel_name(e.sel), e.cyc, actual(e.sel), e.exp);
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic drive(input logic id, input logic [31:0] pc, input logic [1:0] mode,
                         input logic ex, input logic dec, input logic pex,
                         input logic [3:0] idx, input logic [3:0] hist);
        BranchInstructExists_ID = id;
        PC_ID                   = pc;
        Mode                    = mode;
        BranchInstructExists_EX = ex;
        BranchDecision_EX       = dec;
        Prediction_EX           = pex;
        Index_EX                = idx;
        History_EX              = hist;
    endtask

    task automatic expect_val(input int sel, input logic [31:0] v);
        sb.push_back('{cyc, sel, v});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset = 1'b1;
        drive(0, 32'h0, 2'd0, 0, 0, 0, 4'h0, 4'h0);
        step();
        step();

        // Init sequence with an ID branch held throughout.
        Reset = 1'b0;
        drive(1, 32'h40, 2'd1, 0, 0, 0, 4'h0, 4'h0);
        for (int k = 0; k < 16; k++) begin
            expect_val(S_RDY, 0);
            expect_val(S_PRED, 0);
            if (k == 0) begin
                expect_val(S_BCNT, 0);
                expect_val(S_MCNT, 0);
                expect_val(S_HIST, 0);
            end
            step();
        end
        expect_val(S_RDY, 1);
        expect_val(S_PRED, 0);
        expect_val(S_IDX, 0);
        expect_val(S_HIST, 0);
        expect_val(S_BCNT, 0);
        step();

        // Bimodal training of entry 0; same-cycle read sees the old value.
        drive(1, 32'h40, 2'd1, 1, 1, 1, 4'h0, 4'h0);
        expect_val(S_PRED, 0);
        expect_val(S_MISP, 0);
        step();
        expect_val(S_PRED, 1);
        expect_val(S_BCNT, 1);
        step();
        drive(0, 32'h40, 2'd1, 1, 1, 1, 4'h0, 4'h0);
        expect_val(S_PRED, 0);
        expect_val(S_IDX, 0);
        expect_val(S_HIST, 4'b0001);
        expect_val(S_BCNT, 2);
        step();
        // Saturated at 3: two not-taken leave it at 2 then 1.
        drive(1, 32'h40, 2'd1, 1, 0, 0, 4'h0, 4'h0);
        expect_val(S_PRED, 1);
        expect_val(S_MISP, 0);
        expect_val(S_BCNT, 3);
        step();
        expect_val(S_PRED, 1);
        expect_val(S_HIST, 4'b0011);
        step();
        drive(1, 32'h40, 2'd1, 0, 0, 0, 4'h0, 4'h0);
        expect_val(S_PRED, 0);
        expect_val(S_HIST, 4'b0111);
        expect_val(S_BCNT, 5);
        step();

        // Mispredict alongside an ID branch: repair wins.
        drive(1, 32'h40, 2'd1, 1, 1, 0, 4'h5, 4'b1010);
        expect_val(S_MISP, 1);
        expect_val(S_PRED, 0);
        expect_val(S_HIST, 4'b1110);
        expect_val(S_MCNT, 0);
        step();

        // Gshare: 0011 ^ 0101.
        drive(1, 32'h0C, 2'd2, 0, 0, 0, 4'h0, 4'h0);
        expect_val(S_IDX, 4'b0110);
        expect_val(S_HIST, 4'b0101);
        expect_val(S_MCNT, 1);
        expect_val(S_BCNT, 6);
        expect_val(S_MISP, 0);
        expect_val(S_PRED, 0);
        step();
        // Global-only indexes with GHR directly.
        drive(1, 32'h0C, 2'd3, 0, 0, 0, 4'h0, 4'h0);
        expect_val(S_IDX, 4'b1010);
        expect_val(S_HIST, 4'b1010);
        expect_val(S_PRED, 0);
        step();
        // Gshare hit on entry 5 trained by the mispredict resolution.
        drive(1, 32'h04, 2'd2, 0, 0, 0, 4'h0, 4'h0);
        expect_val(S_IDX, 4'b0101);
        expect_val(S_PRED, 1);
        step();

        // Static mode: prediction forced low while EX still trains.
        drive(1, 32'h14, 2'd0, 1, 1, 1, 4'h5, 4'h0);
        expect_val(S_PRED, 0);
        expect_val(S_IDX, 4'h5);
        expect_val(S_BCNT, 6);
        step();
        drive(1, 32'h14, 2'd0, 0, 0, 0, 4'h0, 4'h0);
        expect_val(S_PRED, 0);
        expect_val(S_BCNT, 7);
        expect_val(S_HIST, 4'b0010);
        step();
        drive(1, 32'h14, 2'd1, 0, 0, 0, 4'h0, 4'h0);
        expect_val(S_PRED, 1);
        expect_val(S_IDX, 4'h5);
        expect_val(S_HIST, 4'b0100);
        step();

        // Mid-RUN reset with an EX branch that must be ignored.
        Reset = 1'b1;
        drive(1, 32'h14, 2'd1, 1, 1, 0, 4'h0, 4'h0);
        step();
        Reset = 1'b0;
        drive(1, 32'h14, 2'd1, 1, 1, 0, 4'h0, 4'b1111);
        for (int k = 0; k < 16; k++) begin
            expect_val(S_RDY, 0);
            expect_val(S_PRED, 0);
            expect_val(S_MISP, 0);
            expect_val(S_BCNT, 0);
            expect_val(S_MCNT, 0);
            if (k == 0) expect_val(S_HIST, 0);
            step();
        end
        drive(1, 32'h14, 2'd1, 1, 1, 1, 4'h5, 4'h0);
        expect_val(S_RDY, 1);
        expect_val(S_PRED, 0);
        expect_val(S_BCNT, 0);
        expect_val(S_MCNT, 0);
        expect_val(S_HIST, 0);
        step();
        drive(1, 32'h14, 2'd1, 0, 0, 0, 4'h0, 4'h0);
        expect_val(S_PRED, 1);
        expect_val(S_BCNT, 1);
        step();
        drive(1, 32'h40, 2'd1, 0, 0, 0, 4'h0, 4'h0);
        expect_val(S_PRED, 0);
        expect_val(S_IDX, 0);
        expect_val(S_HIST, 4'b0001);
        step();

        drive(0, 32'h0, 2'd0, 0, 0, 0, 4'h0, 4'h0);
        step();
        step();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor_gshare.md
# branch_predictor_gshare

Parametrised, clocked successor to the single-table history predictor. A per-entry saturating-counter pattern table is indexed by PC, global history, or their XOR, selectable at run time. Global history is updated speculatively at ID and repaired from EX on mispredict. It sits beside the ID stage: it drives the taken/not-taken guess to fetch, and takes resolution from EX.

## Interface
Parameters:
- HIST_BITS, 4: global history length; PHT has 2^HIST_BITS entries
- CTR_BITS, 2: counter width (>=1)
- PC_BITS, 32: PC width
- CNT_BITS, 16: performance-counter width

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  reset, synchronous, active-high
- Mode  in  2  0 static not-taken, 1 bimodal, 2 gshare, 3 global-only
- BranchInstructExists_ID  in  1  branch present in ID this cycle
- PC_ID  in  PC_BITS  PC of ID instruction
- Prediction  out  1  taken guess for ID branch (combinational)
- PredIndex_ID  out  HIST_BITS  PHT index used; carried down pipe
- PredHistory_ID  out  HIST_BITS  GHR value before this branch's shift; carried down pipe
- BranchInstructExists_EX  in  1  branch resolving in EX
- BranchDecision_EX  in  1  actual outcome
- Prediction_EX, Index_EX, History_EX  in  1/HIST_BITS/HIST_BITS  values carried from ID
- Mispredict  out  1  combinational: BranchInstructExists_EX & (Prediction_EX != BranchDecision_EX) & Ready
- Ready  out  1  high when table initialised
- BranchCount, MispredictCount  out  CNT_BITS  resolved-branch and mispredict totals

## Operation
- FSM states INIT, RUN. Reset -> INIT, ptr=0, GHR=0, both perf counters 0. In INIT, write PHT[ptr]=2^(CTR_BITS-1)-1 (weakly not-taken) each cycle; ptr wraps from 2^HIST_BITS-1 -> RUN. Ready=1 only in RUN.
- Index: mode 1 PC_ID[HIST_BITS+1:2]; mode 2 that XOR GHR; mode 3 GHR; mode 0 index computed as mode 1 but Prediction forced 0.
- Prediction = Ready & BranchInstructExists_ID & (mode!=0) & PHT[index][CTR_BITS-1]. Outputs are 0 when no ID branch, except PredHistory_ID, which always shows GHR.
- Speculative update (RUN, ID branch, no Mispredict this cycle): GHR <= {GHR[HIST_BITS-2:0], Prediction}.
- EX resolution (RUN, EX branch): PHT[Index_EX] increments if taken, decrements if not, saturating at 2^CTR_BITS-1 and 0. BranchCount++. On Mispredict: MispredictCount++ and GHR <= {History_EX[HIST_BITS-2:0], BranchDecision_EX}.
- Simultaneous ID and EX with Mispredict: repair wins, ID shift is discarded (ID is flushed). Without mispredict, both apply.
- Same index read at ID and written from EX in one cycle: ID reads the old value (no bypass).
- EX inputs are ignored in INIT.
- Perf counters wrap modulo 2^CNT_BITS.
- Mode change takes effect immediately and does not clear the table.

## Timing
- Prediction, PredIndex_ID, PredHistory_ID, Mispredict: same-cycle combinational.
- PHT and GHR writes are visible the next cycle.
- Init latency is 2^HIST_BITS cycles after Reset deasserts. Ready rises in cycle 2^HIST_BITS (16 for default).
- Reset asserted mid-RUN or mid-INIT restarts INIT next cycle. Table contents are rewritten, and no EX update occurs in the reset cycle.
- Reset values: Prediction 0, Mispredict 0, Ready 0, counts 0, GHR 0.

## Structure
- Shared package holds:
  - mode encodings (MODE_STATIC, MODE_BIMODAL, MODE_GSHARE, MODE_GLOBAL)
  - FSM state enum
  - counter init constant function
- One sub-module, sat_counter_update: CTR_BITS-wide saturating inc/dec, combinational. The PHT stays in the top as a register array.

## Test plan
- Reset, then hold ID branch -> Ready low and Prediction 0 for 16 cycles. Ready=1 in cycle 16, all PHT entries = 1.
- Mode 1, PC 0x40 resolved taken twice -> PHT[0]=3. The third ID lookup of PC 0x40 gives Prediction=1. A further taken stays at 3 (saturation).
- Mode 2, GHR=0101, PC_ID=0x0C -> PredIndex_ID=0011^0101=0110.
- Mispredict: ID branch in the same cycle as EX resolution with History_EX=1010, Prediction_EX=0, Decision=1 -> Mispredict=1, next GHR=0101 (ID shift dropped), MispredictCount=1.
- Mode 0 with taken-trained table -> Prediction stays 0, while EX training still updates the PHT and BranchCount.
- Reset pulsed mid-RUN -> counts 0, Ready 0 for 16 cycles, entries re-initialised to 1.
